// File: rtl/axi4_lite_arbiter_if.sv
// AXI4-Lite bundle used on both upstream master ports and the merged downstream port.
interface axi4_lite_interface #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_arbiter.sv
// 2:1 AXI4-Lite arbiter: IFU (m0) and LSU (m1) share one downstream port.
// One outstanding transaction at a time; the grant is held until its response completes.
module axi4_lite_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ARB_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  axi4_lite_interface.slave   m0,
  axi4_lite_interface.slave   m1,
  axi4_lite_interface.master  s
);
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_D  = 3'd2,
    WR_AW = 3'd3,
    WR_B  = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;
  logic   r_gnt, w_gnt_nxt;
  logic   r_last_gnt, w_last_gnt_nxt;
  logic   r_aw_done, w_aw_done_nxt;
  logic   r_w_done, w_w_done_nxt;

  // Request signals from the currently granted master
  logic                w_sel_arvalid, w_sel_rready, w_sel_awvalid, w_sel_wvalid, w_sel_bready;
  logic [ADDR_W-1:0]   w_sel_araddr, w_sel_awaddr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [STRB_W-1:0]   w_sel_wstrb;

  // Response signals destined for the granted master
  logic                w_rsp_arready, w_rsp_rvalid, w_rsp_awready, w_rsp_wready, w_rsp_bvalid;
  logic [DATA_W-1:0]   w_rsp_rdata;
  logic [1:0]          w_rsp_rresp, w_rsp_bresp;

  logic w_req0, w_req1, w_winner, w_win_ar, w_aw_hs, w_w_hs;

  assign w_sel_arvalid = r_gnt ? m1.arvalid : m0.arvalid;
  assign w_sel_araddr  = r_gnt ? m1.araddr  : m0.araddr;
  assign w_sel_rready  = r_gnt ? m1.rready  : m0.rready;
  assign w_sel_awvalid = r_gnt ? m1.awvalid : m0.awvalid;
  assign w_sel_awaddr  = r_gnt ? m1.awaddr  : m0.awaddr;
  assign w_sel_wvalid  = r_gnt ? m1.wvalid  : m0.wvalid;
  assign w_sel_wdata   = r_gnt ? m1.wdata   : m0.wdata;
  assign w_sel_wstrb   = r_gnt ? m1.wstrb   : m0.wstrb;
  assign w_sel_bready  = r_gnt ? m1.bready  : m0.bready;

  assign w_req0   = m0.arvalid | m0.awvalid;
  assign w_req1   = m1.arvalid | m1.awvalid;
  // Round-robin only matters on contention; otherwise the sole requester wins
  assign w_winner = ((ARB_MODE == 1) && w_req0 && w_req1) ? ~r_last_gnt : w_req1;
  assign w_win_ar = w_winner ? m1.arvalid : m0.arvalid;

  assign w_aw_hs  = w_sel_awvalid & ~r_aw_done & s.awready;
  assign w_w_hs   = w_sel_wvalid  & ~r_w_done  & s.wready;

  // State and grant registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gnt      <= 1'b0;
      r_last_gnt <= 1'b1;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_last_gnt <= w_last_gnt_nxt;
      r_aw_done  <= w_aw_done_nxt;
      r_w_done   <= w_w_done_nxt;
    end
  end

  // Next-state: arbitration in IDLE, then track handshakes of the owned channel
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_last_gnt_nxt = r_last_gnt;
    w_aw_done_nxt  = r_aw_done;
    w_w_done_nxt   = r_w_done;
    case (r_state)
      IDLE: begin
        if (w_req0 | w_req1) begin
          w_gnt_nxt   = w_winner;
          w_state_nxt = w_win_ar ? RD_A : WR_AW;
        end
      end
      RD_A: if (w_sel_arvalid & s.arready) w_state_nxt = RD_D;
      RD_D: begin
        if (w_sel_rready & s.rvalid) begin
          w_state_nxt    = IDLE;
          w_last_gnt_nxt = r_gnt;
        end
      end
      WR_AW: begin
        w_aw_done_nxt = r_aw_done | w_aw_hs;
        w_w_done_nxt  = r_w_done  | w_w_hs;
        if (w_aw_done_nxt & w_w_done_nxt) begin
          w_state_nxt   = WR_B;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end
      end
      WR_B: begin
        if (w_sel_bready & s.bvalid) begin
          w_state_nxt    = IDLE;
          w_last_gnt_nxt = r_gnt;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Downstream routing: only the channel owned by the current state is forwarded
  always_comb begin
    s.arvalid     = 1'b0;
    s.araddr      = '0;
    s.rready      = 1'b0;
    s.awvalid     = 1'b0;
    s.awaddr      = '0;
    s.wvalid      = 1'b0;
    s.wdata       = '0;
    s.wstrb       = '0;
    s.bready      = 1'b0;
    w_rsp_arready = 1'b0;
    w_rsp_rvalid  = 1'b0;
    w_rsp_rdata   = '0;
    w_rsp_rresp   = '0;
    w_rsp_awready = 1'b0;
    w_rsp_wready  = 1'b0;
    w_rsp_bvalid  = 1'b0;
    w_rsp_bresp   = '0;
    case (r_state)
      RD_A: begin
        s.arvalid     = w_sel_arvalid;
        s.araddr      = w_sel_araddr;
        w_rsp_arready = s.arready;
      end
      RD_D: begin
        s.rready     = w_sel_rready;
        w_rsp_rvalid = s.rvalid;
        w_rsp_rdata  = s.rdata;
        w_rsp_rresp  = s.rresp;
      end
      WR_AW: begin
        s.awvalid     = w_sel_awvalid & ~r_aw_done;
        s.awaddr      = w_sel_awaddr;
        w_rsp_awready = s.awready & ~r_aw_done;
        s.wvalid      = w_sel_wvalid & ~r_w_done;
        s.wdata       = w_sel_wdata;
        s.wstrb       = w_sel_wstrb;
        w_rsp_wready  = s.wready & ~r_w_done;
      end
      WR_B: begin
        s.bready     = w_sel_bready;
        w_rsp_bvalid = s.bvalid;
        w_rsp_bresp  = s.bresp;
      end
      default: ;
    endcase
  end

  // Upstream response steering: only the granted master sees responses
  always_comb begin
    m0.arready = 1'b0; m0.rvalid = 1'b0; m0.rdata = '0; m0.rresp = '0;
    m0.awready = 1'b0; m0.wready = 1'b0; m0.bvalid = 1'b0; m0.bresp = '0;
    m1.arready = 1'b0; m1.rvalid = 1'b0; m1.rdata = '0; m1.rresp = '0;
    m1.awready = 1'b0; m1.wready = 1'b0; m1.bvalid = 1'b0; m1.bresp = '0;
    if (r_gnt) begin
      m1.arready = w_rsp_arready; m1.rvalid = w_rsp_rvalid;
      m1.rdata   = w_rsp_rdata;   m1.rresp  = w_rsp_rresp;
      m1.awready = w_rsp_awready; m1.wready = w_rsp_wready;
      m1.bvalid  = w_rsp_bvalid;  m1.bresp  = w_rsp_bresp;
    end else begin
      m0.arready = w_rsp_arready; m0.rvalid = w_rsp_rvalid;
      m0.rdata   = w_rsp_rdata;   m0.rresp  = w_rsp_rresp;
      m0.awready = w_rsp_awready; m0.wready = w_rsp_wready;
      m0.bvalid  = w_rsp_bvalid;  m0.bresp  = w_rsp_bresp;
    end
  end
endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Directed bench: fixed-priority instance for reset/read/write/contention, round-robin instance for alternation.
module tb_axi4_lite_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_aw_hs  = 0;
  int   n_w_hs   = 0;
  int   aw0, w0;

  always #5 clk = ~clk;

  axi4_lite_interface #(.ADDR_W(32), .DATA_W(32)) fm0 ();
  axi4_lite_interface #(.ADDR_W(32), .DATA_W(32)) fm1 ();
  axi4_lite_interface #(.ADDR_W(32), .DATA_W(32)) fs  ();
  axi4_lite_interface #(.ADDR_W(32), .DATA_W(32)) rm0 ();
  axi4_lite_interface #(.ADDR_W(32), .DATA_W(32)) rm1 ();
  axi4_lite_interface #(.ADDR_W(32), .DATA_W(32)) rs  ();

  axi4_lite_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .m0(fm0), .m1(fm1), .s(fs));
  axi4_lite_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .m0(rm0), .m1(rm1), .s(rs));

  // Downstream handshake counters for the fixed-priority instance
  always @(posedge clk) begin
    if (fs.awvalid && fs.awready) n_aw_hs <= n_aw_hs + 1;
    if (fs.wvalid && fs.wready)   n_w_hs  <= n_w_hs + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    fm0.awvalid = 0; fm0.awaddr = '0; fm0.wvalid = 0; fm0.wdata = '0; fm0.wstrb = '0;
    fm0.bready = 0; fm0.arvalid = 0; fm0.araddr = '0; fm0.rready = 0;
    fm1.awvalid = 0; fm1.awaddr = '0; fm1.wvalid = 0; fm1.wdata = '0; fm1.wstrb = '0;
    fm1.bready = 0; fm1.arvalid = 0; fm1.araddr = '0; fm1.rready = 0;
    fs.awready = 0; fs.wready = 0; fs.bvalid = 0; fs.bresp = '0;
    fs.arready = 0; fs.rvalid = 0; fs.rdata = '0; fs.rresp = '0;
    rm0.awvalid = 0; rm0.awaddr = '0; rm0.wvalid = 0; rm0.wdata = '0; rm0.wstrb = '0;
    rm0.bready = 0; rm0.arvalid = 0; rm0.araddr = '0; rm0.rready = 0;
    rm1.awvalid = 0; rm1.awaddr = '0; rm1.wvalid = 0; rm1.wdata = '0; rm1.wstrb = '0;
    rm1.bready = 0; rm1.arvalid = 0; rm1.araddr = '0; rm1.rready = 0;
    rs.awready = 0; rs.wready = 0; rs.bvalid = 0; rs.bresp = '0;
    rs.arready = 0; rs.rvalid = 0; rs.rdata = '0; rs.rresp = '0;
  endtask

  initial begin
    clr_inputs();
    repeat (2) @(posedge clk);
    #1;
    // Reset values
    chk("rst_state",    64'(dut_fp.r_state), 64'd0);
    chk("rst_last_gnt", 64'(dut_fp.r_last_gnt), 64'd1);
    chk("rst_s_arvalid", 64'(fs.arvalid), 64'd0);
    rst_n = 1'b1;
    cyc();

    // Single read from m0
    fm0.arvalid = 1; fm0.araddr = 32'h8000_0000; fm0.rready = 1;
    #1;
    chk("rd_idle_latency", 64'(fs.arvalid), 64'd0);
    cyc();
    chk("rd_s_arvalid", 64'(fs.arvalid), 64'd1);
    chk("rd_s_araddr",  64'(fs.araddr), 64'h8000_0000);
    chk("rd_m0_arready_wait", 64'(fm0.arready), 64'd0);
    chk("rd_m1_arready", 64'(fm1.arready), 64'd0);
    cyc();
    fs.arready = 1;
    #1;
    chk("rd_m0_arready", 64'(fm0.arready), 64'd1);
    cyc();
    fm0.arvalid = 0; fs.arready = 0;
    fs.rvalid = 1; fs.rdata = 32'hDEAD_BEEF; fs.rresp = 2'b00;
    #1;
    chk("rd_m0_rvalid", 64'(fm0.rvalid), 64'd1);
    chk("rd_m0_rdata",  64'(fm0.rdata), 64'hDEAD_BEEF);
    chk("rd_m0_rresp",  64'(fm0.rresp), 64'd0);
    chk("rd_s_rready",  64'(fs.rready), 64'd1);
    chk("rd_m1_rvalid", 64'(fm1.rvalid), 64'd0);
    chk("rd_s_arvalid_off", 64'(fs.arvalid), 64'd0);
    cyc();
    fs.rvalid = 0; fs.rdata = '0;
    #1;
    chk("rd_done_state", 64'(dut_fp.r_state), 64'd0);
    chk("rd_done_m0_rvalid", 64'(fm0.rvalid), 64'd0);

    // Reset asserted while the read data phase is in progress
    fm0.arvalid = 1; fm0.araddr = 32'h0000_0040; fm0.rready = 0;
    fs.arready = 1;
    cyc();
    cyc();
    fm0.arvalid = 0; fs.arready = 0;
    fs.rvalid = 1; fs.rdata = 32'h1234_5678;
    #1;
    chk("rst_pre_m0_rvalid", 64'(fm0.rvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_state",    64'(dut_fp.r_state), 64'd0);
    chk("rst_mid_m0_rvalid", 64'(fm0.rvalid), 64'd0);
    chk("rst_mid_m0_rdata",  64'(fm0.rdata), 64'd0);
    chk("rst_mid_s_rready",  64'(fs.rready), 64'd0);
    chk("rst_mid_valids",
        64'({fs.arvalid, fs.awvalid, fs.wvalid, fs.bready, fm0.arready, fm0.awready,
             fm0.wready, fm0.bvalid, fm1.arready, fm1.rvalid, fm1.awready, fm1.wready, fm1.bvalid}),
        64'd0);
    cyc();
    clr_inputs();
    rst_n = 1'b1;
    cyc();

    // Fixed-priority contention: m1 wins every round
    fm0.arvalid = 1; fm0.araddr = 32'h1000; fm0.rready = 1;
    fm1.arvalid = 1; fm1.araddr = 32'h2000; fm1.rready = 1;
    fs.arready = 1; fs.rvalid = 1; fs.rdata = 32'h1111;
    for (int r = 0; r < 3; r++) begin
      #1;
      chk("fp_idle_arvalid", 64'(fs.arvalid), 64'd0);
      cyc();
      chk("fp_araddr",     64'(fs.araddr), 64'h2000);
      chk("fp_m1_arready", 64'(fm1.arready), 64'd1);
      chk("fp_m0_arready", 64'(fm0.arready), 64'd0);
      cyc();
      chk("fp_m1_rvalid", 64'(fm1.rvalid), 64'd1);
      chk("fp_m0_rvalid", 64'(fm0.rvalid), 64'd0);
      cyc();
    end
    clr_inputs();
    cyc();

    // Write with aw/w skew and an SLVERR response on m1
    aw0 = n_aw_hs; w0 = n_w_hs;
    fm1.awvalid = 1; fm1.awaddr = 32'h3000; fm1.bready = 1; fs.awready = 1;
    #1;
    chk("wr_idle_awvalid", 64'(fs.awvalid), 64'd0);
    cyc();
    chk("wr_s_awvalid", 64'(fs.awvalid), 64'd1);
    chk("wr_s_awaddr",  64'(fs.awaddr), 64'h3000);
    chk("wr_m1_awready", 64'(fm1.awready), 64'd1);
    chk("wr_s_wvalid_early", 64'(fs.wvalid), 64'd0);
    cyc();
    chk("wr_aw_gated",   64'(fs.awvalid), 64'd0);
    chk("wr_awready_gated", 64'(fm1.awready), 64'd0);
    cyc();
    fm1.wvalid = 1; fm1.wdata = 32'hCAFE_F00D; fm1.wstrb = 4'hF;
    #1;
    chk("wr_s_wvalid", 64'(fs.wvalid), 64'd1);
    chk("wr_s_wdata",  64'(fs.wdata), 64'hCAFE_F00D);
    chk("wr_s_wstrb",  64'(fs.wstrb), 64'hF);
    chk("wr_m1_wready_wait", 64'(fm1.wready), 64'd0);
    cyc();
    cyc();
    fs.wready = 1;
    #1;
    chk("wr_m1_wready", 64'(fm1.wready), 64'd1);
    cyc();
    fm1.awvalid = 0; fm1.wvalid = 0; fs.wready = 0; fs.awready = 0;
    fs.bvalid = 1; fs.bresp = 2'b10;
    #1;
    chk("wr_m1_bvalid", 64'(fm1.bvalid), 64'd1);
    chk("wr_m1_bresp",  64'(fm1.bresp), 64'd2);
    chk("wr_s_bready",  64'(fs.bready), 64'd1);
    chk("wr_m0_bvalid", 64'(fm0.bvalid), 64'd0);
    cyc();
    fs.bvalid = 0; fs.bresp = '0;
    #1;
    chk("wr_done_state", 64'(dut_fp.r_state), 64'd0);
    chk("wr_aw_hs_count", 64'(n_aw_hs - aw0), 64'd1);
    chk("wr_w_hs_count",  64'(n_w_hs - w0), 64'd1);

    // Read and write requested together on m1: read first, write after an idle cycle
    aw0 = n_aw_hs; w0 = n_w_hs;
    fm1.arvalid = 1; fm1.araddr = 32'h4000; fm1.rready = 1;
    fm1.awvalid = 1; fm1.awaddr = 32'h5000; fm1.wvalid = 1; fm1.wdata = 32'h55; fm1.wstrb = 4'h3;
    fm1.bready = 1;
    fs.arready = 1; fs.awready = 1; fs.wready = 1;
    cyc();
    chk("rw_rd_first", 64'(fs.arvalid), 64'd1);
    chk("rw_no_aw",    64'(fs.awvalid), 64'd0);
    cyc();
    fm1.arvalid = 0;
    fs.rvalid = 1; fs.rdata = 32'h77; fs.rresp = 2'b00;
    #1;
    chk("rw_rdata", 64'(fm1.rdata), 64'h77);
    chk("rw_no_aw_rd_d", 64'(fs.awvalid), 64'd0);
    cyc();
    fs.rvalid = 0; fs.rdata = '0;
    #1;
    chk("rw_idle_gap", 64'(fs.awvalid), 64'd0);
    cyc();
    chk("rw_s_awvalid", 64'(fs.awvalid), 64'd1);
    chk("rw_s_awaddr",  64'(fs.awaddr), 64'h5000);
    chk("rw_s_wvalid",  64'(fs.wvalid), 64'd1);
    cyc();
    fm1.awvalid = 0; fm1.wvalid = 0;
    fs.bvalid = 1; fs.bresp = 2'b00;
    #1;
    chk("rw_m1_bvalid", 64'(fm1.bvalid), 64'd1);
    cyc();
    clr_inputs();
    #1;
    chk("rw_done_state", 64'(dut_fp.r_state), 64'd0);
    chk("rw_aw_hs_count", 64'(n_aw_hs - aw0), 64'd1);
    chk("rw_w_hs_count",  64'(n_w_hs - w0), 64'd1);

    // Round-robin contention: grants alternate m0, m1, m0, m1
    rm0.arvalid = 1; rm0.araddr = 32'h100; rm0.rready = 1;
    rm1.arvalid = 1; rm1.araddr = 32'h200; rm1.rready = 1;
    rs.arready = 1; rs.rvalid = 1; rs.rdata = 32'h9;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_idle_arvalid", 64'(rs.arvalid), 64'd0);
      cyc();
      chk("rr_araddr",     64'(rs.araddr), (i % 2 == 0) ? 64'h100 : 64'h200);
      chk("rr_m0_arready", 64'(rm0.arready), (i % 2 == 0) ? 64'd1 : 64'd0);
      cyc();
      cyc();
    end
    clr_inputs();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
